// File: rtl/imm_extend_stage.sv
// RISC-V immediate decode/extend stage with a 2-entry valid/ready output FIFO.
// Also keeps a saturating count of requests that used an unsupported format.
module imm_extend_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on registered occupancy, never on out_ready.

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    logic signed [11:0] imm_i, imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    always_comb begin
        imm_i   = instr[31:20];
        imm_s   = {instr[31:25], instr[11:7]};
        imm_b   = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u   = {instr[31:12], 12'b0};
        imm_j   = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec_imm = '0;
        dec_ill = 1'b0;
        case (ImmSrc)
            3'b000: dec_imm = XLEN'(imm_i);
            3'b001: dec_imm = XLEN'(imm_s);
            3'b010: dec_imm = XLEN'(imm_b);
            3'b011: dec_imm = XLEN'(imm_u);
            3'b100: dec_imm = XLEN'(imm_j);
            3'b101: begin
                // RV64 shift amounts are 6 bits, RV32 only 5
                if (XLEN == 64) dec_imm = XLEN'(instr[25:20]);
                else            dec_imm = XLEN'(instr[24:20]);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    logic [1:0]       occ_q, occ_d;
    logic [XLEN-1:0]  imm0_q, imm0_d, imm1_q, imm1_d;
    logic             ill0_q, ill0_d, ill1_q, ill1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Slot 0 is always the head; a pop shifts slot 1 forward
    always_comb begin
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        imm0_d = imm0_q;
        ill0_d = ill0_q;
        imm1_d = imm1_q;
        ill1_d = ill1_q;
        cnt_d  = cnt_q;
        if (pop) begin
            imm0_d = imm1_q;
            ill0_d = ill1_q;
        end
        if (push) begin
            if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
                imm0_d = dec_imm;
                ill0_d = dec_ill;
            end else begin
                imm1_d = dec_imm;
                ill1_d = dec_ill;
            end
            if (dec_ill && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= 2'd0;
            imm0_q <= '0;
            ill0_q <= 1'b0;
            imm1_q <= '0;
            ill1_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            imm0_q <= imm0_d;
            ill0_q <= ill0_d;
            imm1_q <= imm1_d;
            ill1_q <= ill1_d;
            cnt_q  <= cnt_d;
        end
    end

    // Head slot may be stale once drained, so mask it when empty
    assign ImmOp       = out_valid ? imm0_q : '0;
    assign illegal     = out_valid ? ill0_q : 1'b0;
    assign illegal_cnt = cnt_q;

endmodule
